// File: rtl/i2c_write_ctrl.sv
// i2c_write_ctrl: sequences one I2C master write (START, address+W, ACK, data byte, ACK, STOP) per WEI strobe.
// Ports: clk/rst (sync active-high), WEI write strobe, wdata[7:0] payload byte, sda_in sampled SDA level,
//        scl (1 = released), sda_oe (1 = pull SDA low), busy, ack_err (sticky NACK), status = {30'b0, ack_err, busy}.
module i2c_write_ctrl #(
    parameter int         CLK_DIV    = 250,
    parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WEI,
    input  logic [31:0] wdata,
    input  logic        sda_in,
    output logic        scl,
    output logic        sda_oe,
    output logic        busy,
    output logic        ack_err,
    output logic [31:0] status
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          busy_q, busy_d, ack_err_q, ack_err_d;
    logic          q_end, slot_end, sample;
    logic          unused_wdata;
    assign unused_wdata = ^wdata[31:8];
    assign q_end    = (qcnt_q == CW'(CLK_DIV - 1));
    assign slot_end = q_end && (quarter_q == 2'd3);
    // ACK is sampled on the last cycle of q2, while SCL is high
    assign sample   = q_end && (quarter_q == 2'd2);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            ack_err_q <= ack_err_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        busy_d    = busy_q;
        ack_err_d = ack_err_q;
        if (state_q == IDLE) begin
            if (WEI) begin
                state_d   = START;
                data_d    = wdata[7:0];
                shift_d   = {SLAVE_ADDR, 1'b0};
                ack_err_d = 1'b0;
                busy_d    = 1'b1;
                qcnt_d    = '0;
                quarter_d = '0;
                bit_d     = '0;
            end
        end else begin
            qcnt_d    = q_end ? '0 : qcnt_q + 1'b1;
            quarter_d = q_end ? quarter_q + 1'b1 : quarter_q;
            if (sample && (state_q == ACK1 || state_q == ACK2) && sda_in)
                ack_err_d = 1'b1;
            if (slot_end) begin
                case (state_q)
                    START: state_d = ADDR;
                    ADDR, DATA: begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 3'd7)
                            state_d = (state_q == ADDR) ? ACK1 : ACK2;
                    end
                    // ack_err_q already holds the q2 sample of this slot
                    ACK1: begin
                        state_d = ack_err_q ? STOP : DATA;
                        shift_d = ack_err_q ? shift_q : data_q;
                    end
                    ACK2: state_d = STOP;
                    STOP: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end
    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        case (state_q)
            START: sda_oe = quarter_q[1];
            ADDR, DATA: begin
                scl    = quarter_q[1];
                sda_oe = ~shift_q[7];
            end
            ACK1, ACK2: scl = quarter_q[1];
            STOP: begin
                scl    = (quarter_q != 2'd0);
                sda_oe = ~quarter_q[1];
            end
            default: ;
        endcase
    end
    assign busy    = busy_q;
    assign ack_err = ack_err_q;
    assign status  = {30'b0, ack_err_q, busy_q};
endmodule

// File: tb/tb_i2c_write_ctrl.sv
// tb_i2c_write_ctrl: randomized bench for i2c_write_ctrl (CLK_DIV=2 and CLK_DIV=1) against a slot-position model.
module tb_i2c_write_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL D=%0d %s: got %0h, expected %0h at %0t", d, nm, act, exp, $time);
        end
    endtask
    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int D   = (g == 0) ? 2 : 1;
        localparam int NTX = 30;
        logic        rst, wei, sda_in, scl, sda_oe, busy, ack_err;
        logic [31:0] wdata, status;
        i2c_write_ctrl #(.CLK_DIV(D), .SLAVE_ADDR(7'h3C)) dut (
            .clk(clk), .rst(rst), .WEI(wei), .wdata(wdata), .sda_in(sda_in),
            .scl(scl), .sda_oe(sda_oe), .busy(busy), .ack_err(ack_err), .status(status)
        );
        initial begin
            bit          m_busy, m_err, m_n1, p_n1, p_n2, aborted, pscl, psda, pdb;
            int          t, total, txn, gap, rst_at, wei_at, bcnt, nb, slot, q, c;
            logic [7:0]  m_byte, addr_byte;
            logic [31:0] bits;
            logic        e_scl, e_oe;
            addr_byte = 8'h78;
            rst = 1'b1; wei = 1'b0; wdata = '0; sda_in = 1'b0;
            m_busy = 0; m_err = 0; m_n1 = 0; p_n1 = 0; p_n2 = 0; aborted = 0;
            pscl = 1; psda = 0; pdb = 0; m_byte = '0; bits = '0;
            t = 0; total = 20; txn = 0; gap = 3; rst_at = -1; wei_at = -1; bcnt = 0; nb = 0; c = 0;
            @(posedge clk);
            while (!(txn >= NTX && !m_busy && gap == 0)) begin
                c++;
                if (c > 20000) begin
                    chk(D, "timeout_cycles", c, 0);
                    break;
                end
                @(negedge clk);
                slot = t / (4 * D);
                q = (t % (4 * D)) / D;
                e_scl = 1'b1;
                e_oe = 1'b0;
                if (m_busy) begin
                    if (slot == 0) e_oe = (q >= 2);
                    else if (slot == total - 1) begin
                        e_scl = (q != 0);
                        e_oe = (q < 2);
                    end else begin
                        e_scl = (q >= 2);
                        if (slot >= 1 && slot <= 8) e_oe = !addr_byte[8 - slot];
                        else if (slot >= 10 && slot <= 17) e_oe = !m_byte[17 - slot];
                    end
                end
                chk(D, "busy", busy, m_busy);
                chk(D, "scl", scl, e_scl);
                chk(D, "sda_oe", sda_oe, e_oe);
                if (!m_busy || t < 39 * D) begin
                    chk(D, "ack_err", ack_err, m_busy ? 1'b0 : m_err);
                    chk(D, "status", status, {30'b0, m_busy ? 1'b0 : m_err, m_busy});
                end
                if (m_busy && pscl && scl && slot != 0 && slot != total - 1)
                    chk(D, "sda_stable_while_scl_high", sda_oe, psda);
                if (busy && !pscl && scl) begin
                    bits = {bits[30:0], ~sda_oe};
                    nb++;
                end
                if (busy) bcnt++;
                if (pdb && !busy) begin
                    if (!aborted) begin
                        chk(D, "busy_len", bcnt, (D == 2) ? (p_n1 ? 88 : 160) : (p_n1 ? 44 : 80));
                        chk(D, "scl_rises", nb, p_n1 ? 10 : 19);
                        chk(D, "decoded_bits", bits, p_n1 ? {22'b0, 8'h78, 1'b1, 1'b0}
                                                          : {13'b0, 8'h78, 1'b1, m_byte, 2'b10});
                        chk(D, "final_ack_err", ack_err, p_n1 | p_n2);
                        if (p_n1) chk(D, "status_after_nack", status, 32'h2);
                    end
                    bcnt = 0;
                    nb = 0;
                    bits = '0;
                end
                pscl = scl;
                psda = sda_oe;
                pdb = busy;
                wei = 1'b0;
                rst = 1'b0;
                wdata = $urandom;
                sda_in = 1'($urandom_range(0, 1));
                if (m_busy) begin
                    if (t == 39 * D - 1) sda_in = p_n1;
                    if (t == 75 * D - 1) sda_in = p_n2;
                    if (t == wei_at) wei = 1'b1;
                    if (t == rst_at) begin
                        rst = 1'b1;
                        wei = 1'b1;
                    end
                end else if (gap > 0) begin
                    if (gap == 1 && $urandom_range(0, 3) == 0) begin
                        rst = 1'b1;
                        wei = 1'b1;
                    end
                    gap--;
                end else if (txn < NTX) begin
                    wei = 1'b1;
                    p_n1 = ($urandom_range(0, 3) == 0);
                    p_n2 = ($urandom_range(0, 3) == 0);
                    wei_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40 * D)) : -1;
                    rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40 * D)) : -1;
                    gap = int'($urandom_range(0, 5));
                    if (D == 2 && txn < 5) begin
                        wdata = (txn == 3) ? 32'h11 : 32'hA5;
                        p_n1 = (txn == 1);
                        p_n2 = (txn == 2);
                        wei_at = (txn == 3) ? 28 : -1;
                        rst_at = (txn == 4) ? 48 : -1;
                        gap = (txn == 2) ? 0 : 3;
                    end else if (txn == 0) begin
                        wdata = 32'hFF;
                        p_n1 = 0;
                        p_n2 = 0;
                        wei_at = -1;
                        rst_at = -1;
                    end
                    txn++;
                end
                @(posedge clk);
                if (rst) begin
                    if (m_busy) aborted = 1;
                    m_busy = 0;
                    m_err = 0;
                    t = 0;
                end else if (m_busy) begin
                    if (t == 39 * D - 1 && sda_in) begin
                        m_err = 1;
                        m_n1 = 1;
                        total = 11;
                    end
                    if (!m_n1 && t == 75 * D - 1 && sda_in) m_err = 1;
                    t++;
                    if (t == total * 4 * D) m_busy = 0;
                end else if (wei) begin
                    m_busy = 1;
                    t = 0;
                    m_byte = wdata[7:0];
                    m_err = 0;
                    m_n1 = 0;
                    total = 20;
                    aborted = 0;
                end
            end
            n_done++;
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        wait (n_done == 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
